// File: rtl/fp32_sum_normalizer.sv
// Back end of the FP32 adder tree: magnitude, leading-one normalize, round-to-nearest-even
// and binary32 pack, in a 3-stage pipeline with a single global stall.
module fp32_sum_normalizer #(
    parameter int SUM_WIDTH = 31,
    parameter int LEAD_POS  = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] sum_in,
    input  logic [7:0]  exp_in,
    input  logic [1:0]  in_special,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_out,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    localparam int         MantW = 24;
    localparam int         GrdP  = SUM_WIDTH - MantW - 1;
    localparam logic [4:0] TopP  = 5'(SUM_WIDTH - 1);

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Stage 1: register sign and magnitude of the tree sum
    logic [SUM_WIDTH-1:0] s_raw, m_in;
    logic                 v1, sign1;
    logic [SUM_WIDTH-1:0] m1;
    logic [7:0]           exp1;
    logic [1:0]           sp1;

    always_comb begin
        s_raw = sum_in[SUM_WIDTH-1:0];
        m_in  = s_raw[SUM_WIDTH-1] ? (~s_raw + SUM_WIDTH'(1)) : s_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            m1    <= '0;
            exp1  <= '0;
            sp1   <= '0;
        end else if (en) begin
            v1    <= in_valid;
            sign1 <= s_raw[SUM_WIDTH-1];
            m1    <= m_in;
            exp1  <= exp_in;
            sp1   <= in_special;
        end
    end

    // Stage 2: leading-one detect and normalize so the leading one sits at the top bit
    logic [4:0]           lead_p;
    logic [SUM_WIDTH-1:0] n_d;
    logic signed [9:0]    e_d;
    logic                 zero_d;
    logic                 v2, sign2, zero2;
    logic [SUM_WIDTH-1:0] n2;
    logic signed [9:0]    e2;
    logic [1:0]           sp2;

    always_comb begin
        lead_p = '0;
        for (int i = 0; i < SUM_WIDTH; i++) begin
            if (m1[i]) lead_p = 5'(i);
        end
        zero_d = (m1 == '0);
        n_d    = m1 << (TopP - lead_p);
        e_d    = $signed({2'b00, exp1}) + $signed({5'b00000, lead_p}) - $signed(10'(LEAD_POS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            zero2 <= 1'b0;
            n2    <= '0;
            e2    <= '0;
            sp2   <= '0;
        end else if (en) begin
            v2    <= v1;
            sign2 <= sign1;
            zero2 <= zero_d;
            n2    <= n_d;
            e2    <= e_d;
            sp2   <= sp1;
        end
    end

    // Stage 3: round to nearest-even and pack
    logic [MantW-1:0]  mant;
    logic [MantW:0]    mant_r;
    logic [22:0]       frac;
    logic              guard, sticky, rnd, inexact;
    logic signed [9:0] e_f;
    logic [31:0]       fp_d;
    logic              ov_d, un_d, inx_d;
    logic              unused_bits;

    assign unused_bits = sum_in[31] ^ mant_r[MantW-1];

    always_comb begin
        mant    = n2[SUM_WIDTH-1 -: MantW];
        guard   = n2[GrdP];
        sticky  = |n2[GrdP-1:0];
        rnd     = guard & (sticky | mant[0]);
        inexact = guard | sticky;
        mant_r  = {1'b0, mant} + (MantW + 1)'(rnd);
        if (mant_r[MantW]) begin
            frac = '0;
            e_f  = e2 + 10'sd1;
        end else begin
            frac = mant_r[22:0];
            e_f  = e2;
        end

        fp_d  = {sign2, e_f[7:0], frac};
        ov_d  = 1'b0;
        un_d  = 1'b0;
        inx_d = inexact;
        if (sp2 == 2'b11) begin
            fp_d  = 32'h7FC0_0000;
            inx_d = 1'b0;
        end else if (sp2 == 2'b01) begin
            fp_d  = 32'h7F80_0000;
            inx_d = 1'b0;
        end else if (sp2 == 2'b10) begin
            fp_d  = 32'hFF80_0000;
            inx_d = 1'b0;
        end else if (zero2) begin
            fp_d  = 32'h0000_0000;
            inx_d = 1'b0;
        end else if (e_f >= 10'sd255) begin
            fp_d  = {sign2, 8'hFF, 23'b0};
            ov_d  = 1'b1;
            inx_d = 1'b1;
        end else if (e_f <= 10'sd0) begin
            fp_d  = {sign2, 31'b0};
            un_d  = 1'b1;
            inx_d = 1'b1;
        end
    end

    // Bubbles clear the result so flags never show without out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            fp_out         <= '0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (en) begin
            out_valid      <= v2;
            fp_out         <= v2 ? fp_d  : 32'h0;
            flag_overflow  <= v2 & ov_d;
            flag_underflow <= v2 & un_d;
            flag_inexact   <= v2 & inx_d;
        end
    end

endmodule

// File: tb/tb_fp32_sum_normalizer.sv
// Self-checking bench for fp32_sum_normalizer: directed vectors, stall, async reset and a
// randomized stream checked against an arithmetic reference model.
module tb_fp32_sum_normalizer;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] sum_in, fp_out;
    logic [7:0]  exp_in;
    logic [1:0]  in_special;
    logic        flag_overflow, flag_underflow, flag_inexact;

    int checks   = 0;
    int failures = 0;
    logic [34:0] exp_q[$];

    typedef struct {
        logic [31:0] s;
        logic [7:0]  e;
        logic [1:0]  sp;
        logic [34:0] want;
    } vec_t;

    fp32_sum_normalizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .exp_in(exp_in), .in_special(in_special),
        .out_valid(out_valid), .out_ready(out_ready), .fp_out(fp_out),
        .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
        .flag_inexact(flag_inexact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: value = S * 2^(exp-26-127); round the magnitude to 24 significant bits.
    // Returns {fp, overflow, underflow, inexact}.
    function automatic logic [34:0] model(logic [31:0] s_in, logic [7:0] e_in, logic [1:0] sp);
        longint s, m, mant, rem, half;
        int     p, ex, sh;
        logic   sign, inx;
        if (sp == 2'b11) return {32'h7FC00000, 3'b000};
        if (sp == 2'b01) return {32'h7F800000, 3'b000};
        if (sp == 2'b10) return {32'hFF800000, 3'b000};
        s = longint'(s_in[30:0]);
        if (s_in[30]) s = s - (longint'(1) << 31);
        sign = (s < 0);
        m = sign ? -s : s;
        if (m == 0) return 35'd0;
        p = 0;
        for (int i = 0; i < 31; i++) if (m >= (longint'(1) << i)) p = i;
        ex  = int'(e_in) + p - 26;
        sh  = p - 23;
        inx = 1'b0;
        if (sh > 0) begin
            mant = m >> sh;
            rem  = m - (mant << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (mant % 2) == 1)) mant = mant + 1;
            inx = (rem != 0);
        end else begin
            mant = m << (-sh);
        end
        if (mant == (longint'(1) << 24)) begin
            mant = longint'(1) << 23;
            ex   = ex + 1;
        end
        if (ex >= 255) return {sign, 8'hFF, 23'd0, 3'b101};
        if (ex <= 0) return {sign, 31'd0, 3'b011};
        return {sign, 8'(ex), 23'(mant), 2'b00, inx};
    endfunction

    // One cycle of driving; reports what the output showed and what the queue expected.
    task automatic step(input logic iv, input logic [31:0] s, input logic [7:0] e,
                        input logic [1:0] sp, input logic ordy, output logic shown,
                        output logic [34:0] got, output logic [34:0] want,
                        output logic accepted);
        @(negedge clk);
        out_ready  = ordy;
        in_valid   = iv;
        sum_in     = s;
        exp_in     = e;
        in_special = sp;
        #1;
        shown = out_valid;
        got   = {fp_out, flag_overflow, flag_underflow, flag_inexact};
        want  = (exp_q.size() > 0) ? exp_q[0] : 35'bx;
        if (out_valid && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
        accepted = iv && in_ready;
        if (accepted) exp_q.push_back(model(s, e, sp));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sum_in = '0; exp_in = '0; in_special = '0;
        #1;
        checks++;
        if ({out_valid, fp_out, flag_overflow, flag_underflow, flag_inexact} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b fp=%h flags=%b%b%b, want all zero",
                     out_valid, fp_out, flag_overflow, flag_underflow, flag_inexact);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b, want 1/0", in_ready,
                     out_valid);
        end
    endtask

    task automatic test_directed();
        vec_t v[13];
        int   n;
        v[0]  = '{32'h04000000, 8'd127, 2'b00, {32'h3F800000, 3'b000}};
        v[1]  = '{32'h20000000, 8'd127, 2'b00, {32'h41000000, 3'b000}};
        v[2]  = '{32'h7C000000, 8'd127, 2'b00, {32'hBF800000, 3'b000}};
        v[3]  = '{32'h00000000, 8'd127, 2'b00, {32'h00000000, 3'b000}};
        v[4]  = '{32'h04000004, 8'd127, 2'b00, {32'h3F800000, 3'b001}};
        v[5]  = '{32'h0400000C, 8'd127, 2'b00, {32'h3F800002, 3'b001}};
        v[6]  = '{32'h07FFFFFC, 8'd127, 2'b00, {32'h40000000, 3'b001}};
        v[7]  = '{32'h20000000, 8'd254, 2'b00, {32'h7F800000, 3'b101}};
        v[8]  = '{32'h00000008, 8'd1,   2'b00, {32'h00000000, 3'b011}};
        v[9]  = '{32'h12345678, 8'd50,  2'b11, {32'h7FC00000, 3'b000}};
        v[10] = '{32'h12345678, 8'd50,  2'b01, {32'h7F800000, 3'b000}};
        v[11] = '{32'h12345678, 8'd50,  2'b10, {32'hFF800000, 3'b000}};
        v[12] = '{32'hC0000000, 8'd127, 2'b00, {32'hC1800000, 3'b000}};
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1;
            sum_in = v[k].s; exp_in = v[k].e; in_special = v[k].sp;
            @(posedge clk);
            n = 1;
            @(negedge clk);
            in_valid = 1'b0;
            while (!out_valid && n < 10) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            checks++;
            if (n !== 3) begin
                failures++;
                $display("FAIL latency_%0d: got %0d cycles, want 3", k, n);
            end
            checks++;
            if ({fp_out, flag_overflow, flag_underflow, flag_inexact} !== v[k].want) begin
                failures++;
                $display("FAIL vector_%0d: got fp=%h f=%b%b%b, want fp=%h f=%b", k, fp_out,
                         flag_overflow, flag_underflow, flag_inexact, v[k].want[34:3],
                         v[k].want[2:0]);
            end
        end
        @(negedge clk);
        checks++;
        if ({out_valid, flag_overflow, flag_underflow, flag_inexact} !== 4'd0) begin
            failures++;
            $display("FAIL idle_flags: got valid=%b flags=%b%b%b, want 0", out_valid,
                     flag_overflow, flag_underflow, flag_inexact);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s[5];
        logic [7:0]  e[5];
        logic        shown, acc, started;
        logic [34:0] got, want;
        int issued = 0, outs = 0, hold = 0, budget = 0;
        started = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s[i] = $urandom;
            e[i] = 8'($urandom_range(100, 150));
        end
        while ((issued < 5 || outs < 5) && budget < 40) begin
            logic ordy;
            budget++;
            if (out_valid && !started) begin
                started = 1'b1;
                hold    = 4;
            end
            ordy = (hold == 0);
            step(issued < 5, s[issued % 5], e[issued % 5], 2'b00, ordy, shown, got, want, acc);
            if (acc) issued++;
            if (shown) begin
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL b2b_result_%0d: got %h, want %h", outs, got, want);
                end
                if (ordy) outs++;
            end
            if (hold > 0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_stall_ready: got in_ready=%b, want 0", in_ready);
                end
                hold--;
            end
        end
        checks++;
        if (outs !== 5 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL b2b_count: got %0d outputs (%0d pending), want 5 (0)", outs,
                     exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sum_in = 32'h04000000 + i; exp_in = 8'd127; in_special = '0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, fp_out, flag_overflow, flag_underflow, flag_inexact} !== 36'd0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b fp=%h, want 0/0", out_valid, fp_out);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        in_valid = 1'b1; sum_in = 32'h20000000; exp_in = 8'd127;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 3 || fp_out !== 32'h41000000) begin
            failures++;
            $display("FAIL post_reset: got %0d cycles fp=%h, want 3 cycles fp=41000000", n,
                     fp_out);
        end
    endtask

    task automatic test_random();
        logic        shown, acc;
        logic [34:0] got, want;
        logic [31:0] s;
        logic [1:0]  sp;
        int          drain = 0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            s  = $urandom >> $urandom_range(0, 31);
            sp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            step($urandom_range(0, 3) != 0, s, 8'($urandom_range(0, 255)), sp,
                 $urandom_range(0, 3) != 0, shown, got, want, acc);
            if (shown) begin
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL random_%0d: got %h, want %h", c, got, want);
                end
            end
        end
        while (exp_q.size() > 0 && drain < 10) begin
            drain++;
            step(1'b0, '0, '0, '0, 1'b1, shown, got, want, acc);
            if (shown) begin
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL random_drain: got %h, want %h", got, want);
                end
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL random_lost: got %0d results missing, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
